// File: rtl/ram_fifo_pkg.sv
// Shared constants and arbiter state encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    // Records which side won the most recent grant; the other side wins the next contention.
    typedef enum logic {
        LAST_PUSH = 1'b0,
        LAST_POP  = 1'b1
    } arb_state_t;

    // Bit positions inside the two-entry request/grant vectors.
    localparam int REQ_PUSH = 0;
    localparam int REQ_POP  = 1;

endpackage

// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter with a last-grant register.
module arb2_rr
    import ram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    arb_state_t last_grant;

    // A lone requester always wins; on contention the side that did not win last time is chosen.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[REQ_PUSH] = 1'b1;
            2'b10:   grant[REQ_POP]  = 1'b1;
            2'b11: begin
                if (last_grant == LAST_POP) grant[REQ_PUSH] = 1'b1;
                else                        grant[REQ_POP]  = 1'b1;
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner; cycles without a grant leave the history untouched so fairness survives idle gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_POP;
        end else if (grant[REQ_PUSH]) begin
            last_grant <= LAST_PUSH;
        end else if (grant[REQ_POP]) begin
            last_grant <= LAST_POP;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that keeps its storage in an external single-port RAM.
// Each cycle carries at most one RAM access: a push write or a pop read.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ack,
    input  logic              pop_req,
    output logic              pop_ack,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Count value meaning every RAM location holds a word.
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              push_elig;
    logic              pop_elig;
    logic [1:0]        req_vec;
    logic [1:0]        grant_vec;

    assign count = count_q;
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Eligibility is masked by reset so nothing is acknowledged while rst_n is low, and by clr so a flush cycle grants nothing.
    always_comb begin
        push_elig = rst_n && push_req && !full  && !clr;
        pop_elig  = rst_n && pop_req  && !empty && !clr;
        req_vec   = 2'b00;
        req_vec[REQ_PUSH] = push_elig;
        req_vec[REQ_POP]  = pop_elig;
    end

    arb2_rr u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .grant (grant_vec)
    );

    // The RAM port follows the grant; idle cycles issue a harmless read at the read pointer.
    always_comb begin
        push_ack  = grant_vec[REQ_PUSH];
        pop_ack   = grant_vec[REQ_POP];
        ram_wr    = push_ack;
        ram_addr  = push_ack ? wr_ptr : rd_ptr;
        ram_wdata = push_data;
        pop_data  = ram_rdata;
    end

    // Pointer and occupancy bookkeeping; clr wins over any grant and pop_valid tracks the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_ack;
            if (clr) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else if (push_ack) begin
                wr_ptr  <= wr_ptr + 1'b1;
                count_q <= count_q + 1'b1;
            end else if (pop_ack) begin
                rd_ptr  <= rd_ptr + 1'b1;
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised and directed bench for ram_fifo_ctrl with a queue-based reference model and a pop scoreboard.
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       push_req = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop_req = 1'b0;
    logic       push_ack, pop_ack, pop_valid, full, empty, ram_wr;
    logic [7:0] pop_data, ram_wdata, ram_rdata;
    logic [8:0] count;
    logic [7:0] ram_addr;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic [7:0]  mem [0:DEPTH-1];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle_cnt = 0;
    int          fifo_model[$];
    exp_t        expect_q[$];
    int          wr_model = 0;
    int          rd_model = 0;
    bit          push_won_last = 1'b0;

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push_req  (push_req),
        .push_data (push_data),
        .push_ack  (push_ack),
        .pop_req   (pop_req),
        .pop_ack   (pop_ack),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wr    (ram_wr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // External single-port RAM: synchronous write, registered read only on non-write edges.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) cycle_cnt++;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every pop_valid must match the oldest outstanding pop, one cycle after its ack.
    always @(negedge clk) begin
        if (rst_n && pop_valid) begin
            if (expect_q.size() == 0) begin
                checkOutput("unexpected_pop_valid", 1, 0);
            end else begin
                exp_t e;
                e = expect_q.pop_front();
                checkOutput("pop_data", int'(pop_data), e.data);
                checkOutput("pop_latency_cycle", cycle_cnt, e.cyc);
            end
        end
    end

    // One clock cycle of stimulus: predict acks from the model, compare, then advance the model.
    task automatic applyStimulus(input bit pr, input int pd, input bit qr, input bit c);
        int  n;
        bit  pe, qe, ep, eq;
        @(posedge clk);
        #1;
        push_req  = pr;
        push_data = pd[7:0];
        pop_req   = qr;
        clr       = c;
        #1;
        n = fifo_model.size();
        checkOutput("count", int'(count), n);
        checkOutput("full", int'(full), int'(n == DEPTH));
        checkOutput("empty", int'(empty), int'(n == 0));
        pe = pr && (n < DEPTH) && !c;
        qe = qr && (n > 0) && !c;
        ep = pe && (!qe || push_won_last == 1'b0);
        eq = qe && (!pe || push_won_last == 1'b1);
        checkOutput("push_ack", int'(push_ack), int'(ep));
        checkOutput("pop_ack", int'(pop_ack), int'(eq));
        checkOutput("ram_wr", int'(ram_wr), int'(ep));
        checkOutput("ram_addr", int'(ram_addr), ep ? wr_model : rd_model);
        if (ep) checkOutput("ram_wdata", int'(ram_wdata), pd & 8'hFF);
        if (c) begin
            fifo_model.delete();
            wr_model = 0;
            rd_model = 0;
        end else if (ep) begin
            fifo_model.push_back(pd & 8'hFF);
            wr_model = (wr_model + 1) % DEPTH;
            push_won_last = 1'b1;
        end else if (eq) begin
            exp_t e;
            e.data = fifo_model.pop_front();
            e.cyc  = cycle_cnt + 1;
            expect_q.push_back(e);
            rd_model = (rd_model + 1) % DEPTH;
            push_won_last = 1'b0;
        end
    endtask

    // Asynchronous reset in mid-cycle with both requests high; also discards any read in flight.
    task automatic doReset();
        @(posedge clk);
        #3;
        push_req = 1'b1;
        pop_req  = 1'b1;
        clr      = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("reset_push_ack", int'(push_ack), 0);
        checkOutput("reset_pop_ack", int'(pop_ack), 0);
        checkOutput("reset_ram_wr", int'(ram_wr), 0);
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_full", int'(full), 0);
        checkOutput("reset_pop_valid", int'(pop_valid), 0);
        checkOutput("reset_count", int'(count), 0);
        expect_q.delete();
        fifo_model.delete();
        wr_model = 0;
        rd_model = 0;
        push_won_last = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        push_req = 1'b0;
        pop_req  = 1'b0;
        rst_n    = 1'b1;
        #1;
        checkOutput("release_pop_valid", int'(pop_valid), 0);
    endtask

    initial begin
        doReset();

        // Three pushes, then the third write lands on the idle cycle's edge.
        applyStimulus(1, 8'h11, 0, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(1, 8'h33, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mem0", int'(mem[0]), 8'h11);
        checkOutput("mem1", int'(mem[1]), 8'h22);
        checkOutput("mem2", int'(mem[2]), 8'h33);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Fill to capacity, attempt an overflow push, then drain completely across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, 0, 0);
        applyStimulus(1, 8'hEE, 0, 0);
        applyStimulus(1, 8'hEE, 1, 0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Reset with a pop in flight; the pending read must be dropped.
        applyStimulus(1, 8'h5A, 0, 0);
        applyStimulus(0, 0, 1, 0);
        doReset();

        // Five words stored, then contention held for four cycles.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h40 + i, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h80 + i, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Reach ten words, pop once, then flush on the following cycle.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'hC0 + i, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 8'hFF, 1, 1);
        applyStimulus(0, 0, 0, 0);

        // Walk the pointers to 255 and push there, then pop it back after the wrap.
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1, i, 0, 0);
            applyStimulus(0, 0, 1, 0);
        end
        applyStimulus(1, 8'hA5, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrap_mem255", int'(mem[255]), 8'hA5);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 59) == 0));
        end

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("outstanding_pops", expect_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
